soc_system_pcp_0_cpu_0_jtag_ocimem_arb: RTL and testbench
=========================================================

SOC_SYSTEM_PCP_0_CPU_0_JTAG_OCIMEM_ARB -- requirements
Module: soc_system_pcp_0_cpu_0_jtag_ocimem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning debug-RAM word-address width (256 x 32-bit words).
REQ-002 SHALL have ports: clk, input, 1, single clock; reset_n, input, 1, reset, synchronous, active-low.
REQ-003 SHALL have JTAG-side inputs: take_action_ocimem_a, 1, load address/mode; take_action_ocimem_b, 1, write-data strobe; jdo, 38, JTAG data word.
REQ-004 SHALL have JTAG-side outputs: MonDReg, 32, last JTAG read data; jtag_busy, 1, JTAG request pending or in service; jtag_ovf, 1, sticky strobe-dropped flag.
REQ-005 SHALL have CPU Avalon-slave ports: avs_address, in, ADDR_W; avs_read, in, 1; avs_write, in, 1; avs_writedata, in, 32; avs_byteenable, in, 4; avs_readdata, out, 32; avs_waitrequest, out, 1.
REQ-006 SHALL have RAM-port ports: ram_addr, out, ADDR_W; ram_we, out, 1; ram_be, out, 4; ram_wdata, out, 32; ram_rdata, in, 32 (read latency one cycle).

Function
REQ-007 SHALL implement FSM states IDLE, CPU_WR, CPU_RD, CPU_RD2, JTAG_WR, JTAG_RD, JTAG_RD2; every non-IDLE state lasts exactly one cycle.
REQ-008 On take_action_ocimem_a: MonAReg <= jdo[25:18]; jrd_mode <= jdo[17]; jtag_ovf <= 0; when jdo[17]=1, a JTAG read request becomes pending.
REQ-009 On take_action_ocimem_b: MonWData <= jdo[34:3]; a JTAG write request becomes pending.
REQ-010 Both strobes in the same cycle: ocimem_a SHALL win and ocimem_b SHALL be dropped, setting jtag_ovf.
REQ-011 A strobe arriving while a JTAG request is pending or in service SHALL be dropped and set jtag_ovf; MonAReg, MonWData and jrd_mode SHALL be unchanged.
REQ-012 IDLE arbitration: only CPU requests -> CPU; only JTAG pending -> JTAG; both -> the requester not served last (last_grant register, reset value CPU, so JTAG wins the first tie).
REQ-013 CPU_WR: ram_we=1, ram_addr=avs_address, ram_be=avs_byteenable, ram_wdata=avs_writedata, avs_waitrequest=0.
REQ-014 CPU_RD: ram_addr=avs_address, ram_we=0. CPU_RD2: avs_readdata=ram_rdata, avs_waitrequest=0.
REQ-015 avs_waitrequest SHALL be 1 in every state except CPU_WR and CPU_RD2; the CPU SHALL hold address/data stable while waitrequest=1.
REQ-016 JTAG_WR: ram_we=1, ram_be=4'hF, ram_addr=MonAReg, ram_wdata=MonWData; then MonAReg increments.
REQ-017 JTAG_RD: ram_addr=MonAReg. JTAG_RD2: MonDReg <= ram_rdata; MonAReg increments.
REQ-018 MonAReg increment SHALL wrap modulo 2^ADDR_W (255 -> 0 for the default).
REQ-019 jtag_busy SHALL be 1 from the cycle after an accepted strobe until the cycle after JTAG_WR or JTAG_RD2.
REQ-020 ram_we SHALL be 0 in every state other than CPU_WR and JTAG_WR; avs_readdata SHALL hold its last value outside CPU_RD2.
REQ-021 Worst-case CPU wait SHALL be 3 cycles of JTAG service plus its own access; there SHALL be no starvation under continuous requests from both sides.

Reset
REQ-022 While reset_n=0 at a clk edge: state=IDLE; pending requests cleared; MonAReg=0, MonWData=0, MonDReg=0, jrd_mode=0, jtag_ovf=0, last_grant=CPU.
REQ-023 During reset, outputs SHALL be: ram_we=0, avs_waitrequest=1, avs_readdata=0, jtag_busy=0.
REQ-024 Reset asserted mid-access SHALL abort the access with no RAM write in the reset cycle.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding, the jdo field positions (addr 25:18, rd 17, wdata 34:3) and the grant enum.
REQ-026 One sub-module SHALL be used: soc_system_pcp_0_cpu_0_jtag_ocimem_req, the JTAG strobe-capture/pending/overflow register block; arbitration and the FSM live in the top.

Verification
REQ-027 Strobe ocimem_a with jdo[25:18]=0x10 and jdo[17]=0, then ocimem_b with wdata 0xDEADBEEF -> RAM word 0x10 = 0xDEADBEEF; MonAReg = 0x11.
REQ-028 Strobe ocimem_a with addr 0xFF and rd=1, RAM[0xFF]=0x12345678 -> MonDReg = 0x12345678 two cycles after grant; MonAReg = 0x00.
REQ-029 CPU read and JTAG write pending in the same IDLE cycle after reset -> JTAG served first; CPU read completes 3 cycles later with correct data; next tie goes to CPU.
REQ-030 ocimem_a and ocimem_b in the same cycle, or ocimem_b while busy -> jtag_ovf=1, no extra write; the next ocimem_a clears jtag_ovf.
REQ-031 CPU write with be=4'b0011 and data 0xAABBCCDD to a word holding 0 -> word = 0x0000CCDD; waitrequest low exactly one cycle.
REQ-032 reset_n=0 in the JTAG_WR cycle -> RAM unchanged, all outputs at their reset values next cycle, jtag_busy=0.

Source files
------------

// File: rtl/soc_system_pcp_0_cpu_0_jtag_ocimem_arb_pkg.sv
// Shared types and constants for the JTAG/CPU debug-RAM arbiter.
package soc_system_pcp_0_cpu_0_jtag_ocimem_arb_pkg;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned BE_W         = 4;
  localparam int unsigned JDO_W        = 38;
  localparam int unsigned JDO_ADDR_HI  = 25;
  localparam int unsigned JDO_ADDR_LO  = 18;
  localparam int unsigned JDO_RD_BIT   = 17;
  localparam int unsigned JDO_WDATA_HI = 34;
  localparam int unsigned JDO_WDATA_LO = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CPU_WR   = 3'd1,
    ST_CPU_RD   = 3'd2,
    ST_CPU_RD2  = 3'd3,
    ST_JTAG_WR  = 3'd4,
    ST_JTAG_RD  = 3'd5,
    ST_JTAG_RD2 = 3'd6
  } state_e;

  typedef enum logic {
    GNT_CPU  = 1'b0,
    GNT_JTAG = 1'b1
  } grant_e;

endpackage

// File: rtl/soc_system_pcp_0_cpu_0_jtag_ocimem_arb_if.sv
// CPU-side Avalon-MM slave bus into the debug-RAM arbiter.
interface soc_system_pcp_0_cpu_0_jtag_ocimem_arb_if
  import soc_system_pcp_0_cpu_0_jtag_ocimem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [DATA_W-1:0] avs_writedata;
  logic [BE_W-1:0]   avs_byteenable;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_waitrequest;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    output avs_readdata, avs_waitrequest
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    input  avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/soc_system_pcp_0_cpu_0_jtag_ocimem_req.sv
// JTAG strobe capture: address/write-data registers, pending request,
// busy tracking and sticky overflow for dropped strobes.
module soc_system_pcp_0_cpu_0_jtag_ocimem_req
  import soc_system_pcp_0_cpu_0_jtag_ocimem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              take_a_i,
  input  logic              take_b_i,
  input  logic [JDO_W-1:0]  jdo_i,
  input  logic              grant_i,     // arbiter granted the pending request
  input  logic              done_i,      // last cycle of JTAG service
  output logic [ADDR_W-1:0] mon_addr_o,
  output logic [DATA_W-1:0] mon_wdata_o,
  output logic              pend_o,
  output logic              pend_rd_o,
  output logic              busy_o,
  output logic              ovf_o
);

  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              jrd_q,   jrd_d;
  logic              pend_q,  pend_d;
  logic              wr_q,    wr_d;
  logic              busy_q,  busy_d;
  logic              ovf_q,   ovf_d;
  logic              jdo_unused;

  assign jdo_unused = ^{jdo_i[JDO_W-1:JDO_WDATA_HI+1], jdo_i[JDO_WDATA_LO-1:0]};

  // Strobe acceptance/drop, request lifetime and address auto-increment.
  // A request is a write when it came from strobe b; jrd_mode alone cannot
  // tell because it keeps its value across a later write strobe.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    jrd_d   = jrd_q;
    pend_d  = pend_q;
    wr_d    = wr_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    if (take_a_i || take_b_i) begin
      if (busy_q) begin
        ovf_d = 1'b1;
      end else if (take_a_i) begin
        addr_d = ADDR_W'(jdo_i[JDO_ADDR_HI:JDO_ADDR_LO]);
        jrd_d  = jdo_i[JDO_RD_BIT];
        ovf_d  = take_b_i;
        wr_d   = 1'b0;
        if (jdo_i[JDO_RD_BIT]) begin
          pend_d = 1'b1;
          busy_d = 1'b1;
        end
      end else begin
        wdata_d = jdo_i[JDO_WDATA_HI:JDO_WDATA_LO];
        wr_d    = 1'b1;
        pend_d  = 1'b1;
        busy_d  = 1'b1;
      end
    end
    if (grant_i) pend_d = 1'b0;
    if (done_i) begin
      busy_d = 1'b0;
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  // Request-block registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
      jrd_q   <= 1'b0;
      pend_q  <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      jrd_q   <= jrd_d;
      pend_q  <= pend_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign mon_addr_o  = addr_q;
  assign mon_wdata_o = wdata_q;
  assign pend_o      = pend_q;
  assign pend_rd_o   = jrd_q & ~wr_q;
  assign busy_o      = busy_q;
  assign ovf_o       = ovf_q;

endmodule

// File: rtl/soc_system_pcp_0_cpu_0_jtag_ocimem_arb.sv
// Debug-RAM arbiter: shares one single-port RAM between the CPU Avalon
// slave and the JTAG debug path with round-robin tie breaking.
module soc_system_pcp_0_cpu_0_jtag_ocimem_arb
  import soc_system_pcp_0_cpu_0_jtag_ocimem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [JDO_W-1:0]  jdo,
  output logic [DATA_W-1:0] MonDReg,
  output logic              jtag_busy,
  output logic              jtag_ovf,
  soc_system_pcp_0_cpu_0_jtag_ocimem_arb_if.slave avs,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [BE_W-1:0]   ram_be,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_e            state_q, state_d;
  grant_e            last_q,  last_d;
  logic [DATA_W-1:0] mondreg_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] mon_addr;
  logic [DATA_W-1:0] mon_wdata;
  logic              jtag_pend, jtag_rd, jtag_grant, jtag_done, busy;
  logic              cpu_req;

  soc_system_pcp_0_cpu_0_jtag_ocimem_req #(.ADDR_W(ADDR_W)) u_req (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .take_a_i    (take_action_ocimem_a),
    .take_b_i    (take_action_ocimem_b),
    .jdo_i       (jdo),
    .grant_i     (jtag_grant),
    .done_i      (jtag_done),
    .mon_addr_o  (mon_addr),
    .mon_wdata_o (mon_wdata),
    .pend_o      (jtag_pend),
    .pend_rd_o   (jtag_rd),
    .busy_o      (busy),
    .ovf_o       (jtag_ovf)
  );

  assign cpu_req = avs.avs_read | avs.avs_write;

  // State and last-grant registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      last_q  <= GNT_CPU;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next state: IDLE arbitration favours whoever was not served last.
  always_comb begin
    state_d    = ST_IDLE;
    last_d     = last_q;
    jtag_grant = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (jtag_pend && (!cpu_req || last_q == GNT_CPU)) begin
          jtag_grant = 1'b1;
          last_d     = GNT_JTAG;
          state_d    = jtag_rd ? ST_JTAG_RD : ST_JTAG_WR;
        end else if (cpu_req) begin
          last_d  = GNT_CPU;
          state_d = avs.avs_write ? ST_CPU_WR : ST_CPU_RD;
        end
      end
      ST_CPU_RD:  state_d = ST_CPU_RD2;
      ST_JTAG_RD: state_d = ST_JTAG_RD2;
      default:    state_d = ST_IDLE;
    endcase
  end

  // RAM port and Avalon outputs decoded from state; reset forces them idle.
  always_comb begin
    ram_addr            = avs.avs_address;
    ram_we              = 1'b0;
    ram_be              = avs.avs_byteenable;
    ram_wdata           = avs.avs_writedata;
    avs.avs_waitrequest = 1'b1;
    avs.avs_readdata    = rdata_q;
    jtag_done           = 1'b0;
    unique case (state_q)
      ST_CPU_WR: begin
        ram_we              = 1'b1;
        avs.avs_waitrequest = 1'b0;
      end
      ST_CPU_RD2: begin
        avs.avs_waitrequest = 1'b0;
        avs.avs_readdata    = ram_rdata;
      end
      ST_JTAG_WR: begin
        ram_addr  = mon_addr;
        ram_we    = 1'b1;
        ram_be    = '1;
        ram_wdata = mon_wdata;
        jtag_done = 1'b1;
      end
      ST_JTAG_RD: ram_addr = mon_addr;
      ST_JTAG_RD2: begin
        ram_addr  = mon_addr;
        jtag_done = 1'b1;
      end
      default: ;
    endcase
    if (!reset_n) begin
      ram_we              = 1'b0;
      avs.avs_waitrequest = 1'b1;
      avs.avs_readdata    = '0;
    end
  end

  // Capture read data for the JTAG monitor and hold the last CPU read.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mondreg_q <= '0;
      rdata_q   <= '0;
    end else begin
      if (state_q == ST_JTAG_RD2) mondreg_q <= ram_rdata;
      if (state_q == ST_CPU_RD2)  rdata_q   <= ram_rdata;
    end
  end

  assign MonDReg   = mondreg_q;
  assign jtag_busy = busy & reset_n;

endmodule

// File: tb/tb_soc_system_pcp_0_cpu_0_jtag_ocimem_arb.sv
// Directed bench for the JTAG/CPU debug-RAM arbiter with a 1-cycle RAM model.
module tb_soc_system_pcp_0_cpu_0_jtag_ocimem_arb;

  typedef struct {
    bit          we;
    logic [7:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          exp_waits;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        take_a = 1'b0;
  logic        take_b = 1'b0;
  logic [37:0] jdo = '0;
  logic [31:0] MonDReg;
  logic        jtag_busy, jtag_ovf;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;

  logic [31:0] mem [256] = '{default: '0};
  int          cyc = 0;
  int          last_we_cyc = -1;
  int          n_chk = 0;
  int          n_fail = 0;

  soc_system_pcp_0_cpu_0_jtag_ocimem_arb_if #(.ADDR_W(8)) avs_if ();

  soc_system_pcp_0_cpu_0_jtag_ocimem_arb #(.ADDR_W(8)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .take_action_ocimem_a (take_a),
    .take_action_ocimem_b (take_b),
    .jdo                  (jdo),
    .MonDReg              (MonDReg),
    .jtag_busy            (jtag_busy),
    .jtag_ovf             (jtag_ovf),
    .avs                  (avs_if),
    .ram_addr             (ram_addr),
    .ram_we               (ram_we),
    .ram_be               (ram_be),
    .ram_wdata            (ram_wdata),
    .ram_rdata            (ram_rdata)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      last_we_cyc <= cyc;
    end
    ram_rdata <= mem[ram_addr];
    cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic strobe_a(input logic [7:0] a, input bit rd);
    jdo = '0; jdo[25:18] = a; jdo[17] = rd;
    take_a = 1'b1;
    @(negedge clk);
    take_a = 1'b0; jdo = '0;
  endtask

  task automatic strobe_b(input logic [31:0] d);
    jdo = '0; jdo[34:3] = d;
    take_b = 1'b1;
    @(negedge clk);
    take_b = 1'b0; jdo = '0;
  endtask

  task automatic strobe_ab(input logic [7:0] a, input bit rd);
    jdo = '0; jdo[25:18] = a; jdo[17] = rd;
    take_a = 1'b1; take_b = 1'b1;
    @(negedge clk);
    take_a = 1'b0; take_b = 1'b0; jdo = '0;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (jtag_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("busy_bound", {31'b0, jtag_busy}, 32'd0);
  endtask

  task automatic cpu_access(input bit we, input logic [7:0] a, input logic [3:0] be,
                            input logic [31:0] d, output logic [31:0] rd,
                            output int waits, output int done);
    avs_if.avs_address    = a;
    avs_if.avs_byteenable = be;
    avs_if.avs_writedata  = d;
    avs_if.avs_write      = we;
    avs_if.avs_read       = !we;
    waits = 0;
    while (avs_if.avs_waitrequest && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    check("cpu_wait_bound", {31'b0, avs_if.avs_waitrequest}, 32'd0);
    rd   = avs_if.avs_readdata;
    done = cyc;
    @(negedge clk);
    avs_if.avs_read  = 1'b0;
    avs_if.avs_write = 1'b0;
  endtask

  initial begin
    vec_t        vecs [11];
    logic [31:0] rd;
    int          w, d, n, start;

    vecs[0]  = '{1'b1, 8'h80, 4'hF,    32'h11223344, 32'h11223344, 1};
    vecs[1]  = '{1'b0, 8'h80, 4'hF,    32'h0,        32'h11223344, 2};
    vecs[2]  = '{1'b1, 8'h81, 4'b0011, 32'hAABBCCDD, 32'h0000CCDD, 1};
    vecs[3]  = '{1'b0, 8'h81, 4'hF,    32'h0,        32'h0000CCDD, 2};
    vecs[4]  = '{1'b1, 8'h81, 4'b1100, 32'h55667788, 32'h5566CCDD, 1};
    vecs[5]  = '{1'b0, 8'h81, 4'hF,    32'h0,        32'h5566CCDD, 2};
    vecs[6]  = '{1'b1, 8'hFF, 4'b1000, 32'hAB000000, 32'hAB345678, 1};
    vecs[7]  = '{1'b0, 8'hFF, 4'hF,    32'h0,        32'hAB345678, 2};
    vecs[8]  = '{1'b1, 8'h82, 4'b0000, 32'hFFFFFFFF, 32'h00000000, 1};
    vecs[9]  = '{1'b0, 8'h82, 4'hF,    32'h0,        32'h00000000, 2};
    vecs[10] = '{1'b0, 8'h80, 4'hF,    32'h0,        32'h11223344, 2};

    avs_if.avs_address = '0; avs_if.avs_read = 1'b0; avs_if.avs_write = 1'b0;
    avs_if.avs_writedata = '0; avs_if.avs_byteenable = '0;

    repeat (3) @(negedge clk);
    check("rst_ram_we",   {31'b0, ram_we}, 32'd0);
    check("rst_waitreq",  {31'b0, avs_if.avs_waitrequest}, 32'd1);
    check("rst_readdata", avs_if.avs_readdata, 32'd0);
    check("rst_busy",     {31'b0, jtag_busy}, 32'd0);
    check("rst_ovf",      {31'b0, jtag_ovf}, 32'd0);
    check("rst_mondreg",  MonDReg, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // First tie after reset: JTAG write wins, CPU read follows.
    cpu_access(1'b1, 8'h30, 4'hF, 32'hCAFEF00D, rd, w, d);
    check("preload_waits", w, 1);
    strobe_a(8'h40, 1'b0);
    strobe_b(32'h0BADF00D);
    start = cyc;
    cpu_access(1'b0, 8'h30, 4'hF, 32'h0, rd, w, d);
    check("tie1_rdata", rd, 32'hCAFEF00D);
    check("tie1_waits", w, 4);
    check("tie1_jtag_first", {31'b0, (last_we_cyc >= start) && (last_we_cyc < d)}, 32'd1);
    wait_busy(n);
    check("tie1_ram40", mem[8'h40], 32'h0BADF00D);

    // JTAG served alone, so the next tie goes to the CPU.
    strobe_a(8'h50, 1'b0);
    strobe_b(32'h11111111);
    wait_busy(n);
    check("jwr_busy_cycles", n, 2);
    check("jwr_ram50", mem[8'h50], 32'h11111111);
    strobe_b(32'h22222222);
    start = cyc;
    cpu_access(1'b0, 8'h30, 4'hF, 32'h0, rd, w, d);
    check("tie2_rdata", rd, 32'hCAFEF00D);
    check("tie2_waits", w, 2);
    check("tie2_cpu_first", {31'b0, last_we_cyc < start}, 32'd1);
    wait_busy(n);
    check("tie2_ram51", mem[8'h51], 32'h22222222);

    // JTAG write then auto-increment.
    strobe_a(8'h10, 1'b0);
    strobe_b(32'hDEADBEEF);
    wait_busy(n);
    check("jwr_ram10", mem[8'h10], 32'hDEADBEEF);
    strobe_b(32'h5A5A0011);
    wait_busy(n);
    check("monareg_inc", mem[8'h11], 32'h5A5A0011);

    // JTAG read at the top address, then address wraps to 0.
    cpu_access(1'b1, 8'hFF, 4'hF, 32'h12345678, rd, w, d);
    strobe_a(8'hFF, 1'b1);
    check("rd_busy_set", {31'b0, jtag_busy}, 32'd1);
    wait_busy(n);
    check("jrd_busy_cycles", n, 3);
    check("jrd_mondreg", MonDReg, 32'h12345678);
    strobe_b(32'h00000077);
    wait_busy(n);
    check("monareg_wrap", mem[8'h00], 32'h00000077);

    // Overflow: simultaneous strobes, then strobe while busy.
    strobe_ab(8'h60, 1'b0);
    check("ovf_same_cycle", {31'b0, jtag_ovf}, 32'd1);
    check("ovf_no_request", {31'b0, jtag_busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("ovf_no_write", mem[8'h60], 32'd0);
    strobe_a(8'h60, 1'b0);
    check("ovf_clear1", {31'b0, jtag_ovf}, 32'd0);
    strobe_b(32'h000000A1);
    strobe_b(32'h000000B2);
    check("ovf_busy_drop", {31'b0, jtag_ovf}, 32'd1);
    wait_busy(n);
    repeat (2) @(negedge clk);
    check("ovf_kept_data", mem[8'h60], 32'h000000A1);
    check("ovf_no_extra_wr", mem[8'h61], 32'd0);
    strobe_a(8'h62, 1'b0);
    check("ovf_clear2", {31'b0, jtag_ovf}, 32'd0);

    // CPU vector table: byte enables, wait counts, read-data hold.
    for (int i = 0; i < 11; i++) begin
      cpu_access(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, rd, w, d);
      check($sformatf("vec%0d_waits", i), w, vecs[i].exp_waits);
      if (vecs[i].we) begin
        check($sformatf("vec%0d_ram", i), mem[vecs[i].addr], vecs[i].exp);
        check($sformatf("vec%0d_wait_back", i), {31'b0, avs_if.avs_waitrequest}, 32'd1);
      end else begin
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
        check($sformatf("vec%0d_hold", i), avs_if.avs_readdata, vecs[i].exp);
      end
    end

    // Reset during JTAG_WR aborts the write.
    strobe_a(8'h70, 1'b0);
    strobe_b(32'h000000EE);
    @(negedge clk);
    check("jwr_cycle_we", {31'b0, ram_we}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rstmid_we", {31'b0, ram_we}, 32'd0);
    check("rstmid_waitreq", {31'b0, avs_if.avs_waitrequest}, 32'd1);
    @(negedge clk);
    check("rstpost_busy", {31'b0, jtag_busy}, 32'd0);
    check("rstpost_mondreg", MonDReg, 32'd0);
    check("rstpost_ovf", {31'b0, jtag_ovf}, 32'd0);
    check("rstpost_readdata", avs_if.avs_readdata, 32'd0);
    check("rstpost_waitreq", {31'b0, avs_if.avs_waitrequest}, 32'd1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_abort_nowrite", mem[8'h70], 32'd0);
    strobe_b(32'h00000033);
    wait_busy(n);
    check("rst_monareg_zero", mem[8'h00], 32'h00000033);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
